// File: rtl/id_issue_stage.sv
// id_issue_stage: decode-to-execute issue buffer.
// One entry slot holds a decoded instruction while the hazard unit inspects its
// register tuple; the instruction moves into the EX output register once it is
// hazard-free and EX can take it.
// Optional build macro ISSUE_STALL_CNT_EN adds saturating stall counters.

package id_issue_pkg;
    localparam int unsigned REG_W = 5;

    // Register tuple handed to the hazard detection unit.
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } hazard_detection_t;

    // Decoded view of the entry slot; only the full flag is stored.
    typedef enum logic [1:0] {
        SLOT_EMPTY     = 2'd0,
        SLOT_HELD      = 2'd1,
        SLOT_STALL_HAZ = 2'd2,
        SLOT_STALL_EX  = 2'd3
    } slot_state_e;
endpackage

module id_issue_stage
    import id_issue_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 96
`ifdef ISSUE_STALL_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [REG_W-1:0]     dec_rs1_i,
    input  logic [REG_W-1:0]     dec_rs2_i,
    input  logic [REG_W-1:0]     dec_rd_i,
    input  logic [PAYLOAD_W-1:0] dec_payload_i,
    output hazard_detection_t    id_dep_o,
    input  logic                 no_hazard_i,
    output logic                 id_commit_o,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [REG_W-1:0]     ex_rs1_o,
    output logic [REG_W-1:0]     ex_rs2_o,
    output logic [REG_W-1:0]     ex_rd_o,
    output logic [PAYLOAD_W-1:0] ex_payload_o,
    input  logic                 flush_i
`ifdef ISSUE_STALL_CNT_EN
    , output logic [CNT_W-1:0]   haz_stall_cnt_o
    , output logic [CNT_W-1:0]   ex_stall_cnt_o
`endif
);

    logic                 full_q,     full_d;
    hazard_detection_t    ent_tup_q,  ent_tup_d;
    logic [PAYLOAD_W-1:0] ent_pl_q,   ent_pl_d;
    logic                 ex_valid_q, ex_valid_d;
    hazard_detection_t    ex_tup_q,   ex_tup_d;
    logic [PAYLOAD_W-1:0] ex_pl_q,    ex_pl_d;

    logic        ex_free;
    logic        issue;
    logic        dec_ready;
    logic        accept;
    slot_state_e slot_state;

    // Decode slot state and the issue/accept handshakes for this cycle.
    always_comb begin
        ex_free = ~ex_valid_q | ex_ready_i;

        slot_state = SLOT_EMPTY;
        if (full_q) begin
            if (!no_hazard_i) begin
                slot_state = SLOT_STALL_HAZ;
            end else if (!ex_free) begin
                slot_state = SLOT_STALL_EX;
            end else begin
                slot_state = SLOT_HELD;
            end
        end

        // Reset and flush both suppress issue; flush discards the slot instead.
        issue     = (slot_state == SLOT_HELD) & ~flush_i & ~rst_i;
        dec_ready = ~rst_i & ~flush_i & (~full_q | issue);
        accept    = dec_valid_i & dec_ready;
    end

    // Next-state for entry slot and EX register.
    always_comb begin
        full_d     = full_q;
        ent_tup_d  = ent_tup_q;
        ent_pl_d   = ent_pl_q;
        ex_valid_d = ex_valid_q;
        ex_tup_d   = ex_tup_q;
        ex_pl_d    = ex_pl_q;

        if (flush_i) begin
            full_d     = 1'b0;
            ex_valid_d = 1'b0;
        end else begin
            if (issue) begin
                ex_valid_d = 1'b1;
                ex_tup_d   = ent_tup_q;
                ex_pl_d    = ent_pl_q;
            end else if (ex_valid_q && ex_ready_i) begin
                ex_valid_d = 1'b0;
            end

            if (accept) begin
                full_d        = 1'b1;
                ent_tup_d.rs1 = dec_rs1_i;
                ent_tup_d.rs2 = dec_rs2_i;
                ent_tup_d.rd  = dec_rd_i;
                ent_pl_d      = dec_payload_i;
            end else if (issue) begin
                full_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q     <= 1'b0;
            ent_tup_q  <= '0;
            ent_pl_q   <= '0;
            ex_valid_q <= 1'b0;
            ex_tup_q   <= '0;
            ex_pl_q    <= '0;
        end else begin
            full_q     <= full_d;
            ent_tup_q  <= ent_tup_d;
            ent_pl_q   <= ent_pl_d;
            ex_valid_q <= ex_valid_d;
            ex_tup_q   <= ex_tup_d;
            ex_pl_q    <= ex_pl_d;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] haz_cnt_q, haz_cnt_d;
    logic [CNT_W-1:0] exs_cnt_q, exs_cnt_d;

    // Saturating stall counters; flush cycles are not counted.
    always_comb begin
        haz_cnt_d = haz_cnt_q;
        exs_cnt_d = exs_cnt_q;
        if (!flush_i) begin
            if ((slot_state == SLOT_STALL_HAZ) && (haz_cnt_q != '1)) begin
                haz_cnt_d = haz_cnt_q + CNT_W'(1);
            end
            if ((slot_state == SLOT_STALL_EX) && (exs_cnt_q != '1)) begin
                exs_cnt_d = exs_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers, cleared by reset only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            haz_cnt_q <= '0;
            exs_cnt_q <= '0;
        end else begin
            haz_cnt_q <= haz_cnt_d;
            exs_cnt_q <= exs_cnt_d;
        end
    end

    assign haz_stall_cnt_o = haz_cnt_q;
    assign ex_stall_cnt_o  = exs_cnt_q;
`endif

    // Empty slot presents an all-zero tuple, which never matches a hazard.
    assign id_dep_o     = full_q ? ent_tup_q : '0;
    assign dec_ready_o  = dec_ready;
    assign id_commit_o  = issue;
    assign ex_valid_o   = ex_valid_q;
    assign ex_rs1_o     = ex_tup_q.rs1;
    assign ex_rs2_o     = ex_tup_q.rs2;
    assign ex_rd_o      = ex_tup_q.rd;
    assign ex_payload_o = ex_pl_q;

endmodule
